// File: rtl/multi_channel_button_conditioner_if.sv
// Button conditioner bus: raw buttons and lockout config in, conditioned pulses/levels out.
interface multi_channel_button_conditioner_if #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned TICK_W = 8
);
    logic [N_CH-1:0]   btn;
    logic [TICK_W-1:0] lock_ticks;
    logic              clear;
    logic [N_CH-1:0]   press_pulse;
    logic [N_CH-1:0]   level;
    logic [N_CH-1:0]   state;
    logic [N_CH-1:0]   long_pulse;

    modport master (
        output btn, lock_ticks, clear,
        input  press_pulse, level, state, long_pulse
    );

    modport slave (
        input  btn, lock_ticks, clear,
        output press_pulse, level, state, long_pulse
    );
endinterface

// File: rtl/multi_channel_button_conditioner.sv
// N-channel pushbutton conditioner: 2-FF sync, tick-timed press/release lockout, pulse/level/toggle.
// Optional long-hold detection is enabled by defining BTN_LONG_PRESS_EN.
module multi_channel_button_conditioner #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned PRESCALE   = 1000000,
    parameter int unsigned TICK_W     = 8,
    parameter int unsigned LONG_TICKS = 50
) (
    input logic                               clk_ms,
    input logic                               reset,
    multi_channel_button_conditioner_if.slave bus
);
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {StIdle, StPressLock, StHeld, StRelLock} ch_state_e;

    if (PRESCALE < 1 || LONG_TICKS < 1 || LONG_TICKS >= (1 << TICK_W)) begin : g_param_check
        $error("multi_channel_button_conditioner: invalid PRESCALE/LONG_TICKS/TICK_W");
    end

    logic [N_CH-1:0]   sync1_q;
    logic [N_CH-1:0]   s_q;
    logic [PW-1:0]     presc_q;
    logic              tick;
    logic [TICK_W-1:0] lock_len;
    ch_state_e         st_q    [N_CH];
    logic [TICK_W-1:0] cnt_q   [N_CH];
    logic [TICK_W:0]   cnt_inc [N_CH];
    logic [N_CH-1:0]   lock_done;
    logic [N_CH-1:0]   accept;
    logic [N_CH-1:0]   press_q;
    logic [N_CH-1:0]   level_q;
    logic [N_CH-1:0]   state_q;

    assign tick     = (presc_q == PW'(PRESCALE - 1));
    assign lock_len = (bus.lock_ticks == '0) ? TICK_W'(1) : bus.lock_ticks;

    // One extra bit so the live compare against a shrunk lock_ticks cannot overflow.
    always_comb begin
        for (int i = 0; i < int'(N_CH); i++) begin
            cnt_inc[i]   = {1'b0, cnt_q[i]} + {{TICK_W{1'b0}}, tick};
            lock_done[i] = (cnt_inc[i] >= {1'b0, lock_len});
            accept[i]    = (st_q[i] == StIdle) && s_q[i];
        end
    end

    always_ff @(posedge clk_ms or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            s_q     <= '0;
            presc_q <= '0;
        end else begin
            sync1_q <= bus.btn;
            s_q     <= sync1_q;
            presc_q <= tick ? '0 : presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk_ms or posedge reset) begin
        if (reset) begin
            press_q <= '0;
            level_q <= '0;
            state_q <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                st_q[i]  <= StIdle;
                cnt_q[i] <= '0;
            end
        end else begin
            press_q <= accept;
            // A coincident clear overrides the toggle of an accepted press.
            state_q <= bus.clear ? '0 : (state_q ^ accept);
            for (int i = 0; i < int'(N_CH); i++) begin
                unique case (st_q[i])
                    StIdle: begin
                        if (s_q[i]) begin
                            st_q[i]    <= StPressLock;
                            cnt_q[i]   <= '0;
                            level_q[i] <= 1'b1;
                        end
                    end
                    StPressLock: begin
                        if (lock_done[i]) begin
                            cnt_q[i] <= '0;
                            if (s_q[i]) begin
                                st_q[i] <= StHeld;
                            end else begin
                                st_q[i]    <= StRelLock;
                                level_q[i] <= 1'b0;
                            end
                        end else begin
                            cnt_q[i] <= cnt_inc[i][TICK_W-1:0];
                        end
                    end
                    StHeld: begin
                        if (!s_q[i]) begin
                            st_q[i]    <= StRelLock;
                            cnt_q[i]   <= '0;
                            level_q[i] <= 1'b0;
                        end
                    end
                    StRelLock: begin
                        if (lock_done[i]) begin
                            st_q[i]  <= StIdle;
                            cnt_q[i] <= '0;
                        end else begin
                            cnt_q[i] <= cnt_inc[i][TICK_W-1:0];
                        end
                    end
                    default: begin
                        st_q[i]    <= StIdle;
                        cnt_q[i]   <= '0;
                        level_q[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.press_pulse = press_q;
    assign bus.level       = level_q;
    assign bus.state       = state_q;

`ifdef BTN_LONG_PRESS_EN
    logic [TICK_W-1:0] hold_q [N_CH];
    logic [N_CH-1:0]   long_q;

    // Saturates at LONG_TICKS, so the pulse can fire only once per press.
    always_ff @(posedge clk_ms or posedge reset) begin
        if (reset) begin
            long_q <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            long_q <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                if (accept[i]) begin
                    hold_q[i] <= '0;
                end else if (tick && level_q[i] && (hold_q[i] < TICK_W'(LONG_TICKS))) begin
                    hold_q[i] <= hold_q[i] + 1'b1;
                    if ((hold_q[i] + 1'b1) == TICK_W'(LONG_TICKS)) begin
                        long_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.long_pulse = long_q;
`else
    assign bus.long_pulse = '0;
`endif
endmodule

// File: tb/tb_multi_channel_button_conditioner.sv
// Directed bench for multi_channel_button_conditioner (N_CH=4, PRESCALE=4, lock_ticks=3, LONG_TICKS=5).
module tb_multi_channel_button_conditioner;
    logic clk_ms = 1'b0;
    logic reset;

    always #5 clk_ms = ~clk_ms;

    multi_channel_button_conditioner_if #(.N_CH(4), .TICK_W(8)) bus ();

    multi_channel_button_conditioner #(
        .N_CH      (4),
        .PRESCALE  (4),
        .TICK_W    (8),
        .LONG_TICKS(5)
    ) u_dut (
        .clk_ms(clk_ms),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int pulse_cnt [4] = '{default: 0};
    int rise_cnt  [4] = '{default: 0};
    int fall_cnt  [4] = '{default: 0};
    int long_cnt  [4] = '{default: 0};
    logic [3:0] lvl_prev = 4'b0000;

    // Event counters sampled mid-cycle, well clear of both clock edges.
    always @(posedge clk_ms) begin
        #2;
        for (int i = 0; i < 4; i++) begin
            if (bus.press_pulse[i] === 1'b1) pulse_cnt[i]++;
            if (bus.long_pulse[i] === 1'b1) long_cnt[i]++;
            if (bus.level[i] === 1'b1 && lvl_prev[i] === 1'b0) rise_cnt[i]++;
            if (bus.level[i] === 1'b0 && lvl_prev[i] === 1'b1) fall_cnt[i]++;
        end
        lvl_prev = bus.level;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_ms);
    endtask

    logic [7:0] press_pat;
    logic [7:0] rel_pat;

    initial begin
        press_pat = 8'b1101_0101;  // LSB first: 1,0,1,0,1,0,1,1
        rel_pat   = 8'b0010_1010;  // LSB first: 0,1,0,1,0,1,0,0
        reset          = 1'b1;
        bus.btn        = 4'b0000;
        bus.lock_ticks = 8'd3;
        bus.clear      = 1'b0;
        cyc(3);
        chk("rst_level", 32'(bus.level), 32'h0);
        chk("rst_state", 32'(bus.state), 32'h0);
        chk("rst_pulse", 32'(bus.press_pulse), 32'h0);
        chk("rst_long", 32'(bus.long_pulse), 32'h0);
        reset = 1'b0;
        cyc(5);

        // Clean press on channel 0
        bus.btn = 4'b0001;
        cyc(2);
        chk("t1_no_early_pulse", 32'(bus.press_pulse), 32'h0);
        cyc(1);
        chk("t1_pulse", 32'(bus.press_pulse), 32'h1);
        chk("t1_state", 32'(bus.state), 32'h1);
        chk("t1_level", 32'(bus.level), 32'h1);
        cyc(1);
        chk("t1_pulse_one_cycle", 32'(bus.press_pulse), 32'h0);
        cyc(56);
        chk("t1_level_held", 32'(bus.level), 32'h1);
        bus.btn = 4'b0000;
        cyc(2);
        chk("t1_level_lag", 32'(bus.level), 32'h1);
        cyc(1);
        chk("t1_level_fall", 32'(bus.level), 32'h0);
        cyc(20);
        chk("t1_pulse_count", 32'(pulse_cnt[0]), 32'd1);
        chk("t1_other_pulses", 32'(pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]), 32'd0);
        chk("t1_state_end", 32'(bus.state), 32'h1);

        // Bouncy press and bouncy release on channel 1
        for (int k = 0; k < 8; k++) begin
            bus.btn[1] = press_pat[k];
            cyc(1);
        end
        cyc(30);
        chk("t2_level_held", 32'(bus.level), 32'h2);
        for (int k = 0; k < 8; k++) begin
            bus.btn[1] = rel_pat[k];
            cyc(1);
        end
        cyc(25);
        chk("t2_pulse_count", 32'(pulse_cnt[1]), 32'd1);
        chk("t2_level_rises", 32'(rise_cnt[1]), 32'd1);
        chk("t2_level_falls", 32'(fall_cnt[1]), 32'd1);
        chk("t2_state", 32'(bus.state), 32'h3);
        chk("t2_level_end", 32'(bus.level), 32'h0);

        // Clear all toggle states
        bus.clear = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
        chk("clr_state", 32'(bus.state), 32'h0);

        // Simultaneous presses on channels 1 and 3, twice
        bus.btn = 4'b1010;
        cyc(2);
        chk("t3_no_early_pulse", 32'(bus.press_pulse), 32'h0);
        cyc(1);
        chk("t3_pulse_a", 32'(bus.press_pulse), 32'hA);
        chk("t3_state_a", 32'(bus.state), 32'hA);
        cyc(11);
        bus.btn = 4'b0000;
        cyc(25);
        bus.btn = 4'b1010;
        cyc(3);
        chk("t3_pulse_b", 32'(bus.press_pulse), 32'hA);
        chk("t3_state_b", 32'(bus.state), 32'h0);
        cyc(11);
        bus.btn = 4'b0000;
        cyc(25);

        // Clear coincident with the press on channel 2
        bus.btn = 4'b0100;
        cyc(2);
        bus.clear = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
        chk("t4_pulse", 32'(bus.press_pulse), 32'h4);
        chk("t4_state", 32'(bus.state), 32'h0);
        cyc(1);
        chk("t4_state_after", 32'(bus.state), 32'h0);
        cyc(10);
        bus.btn = 4'b0000;
        cyc(25);

        // Reset while channel 0 is held
        bus.btn = 4'b0001;
        cyc(30);
        chk("t5_held_level", 32'(bus.level), 32'h1);
        chk("t5_held_state", 32'(bus.state), 32'h1);
        reset = 1'b1;
        #1;
        chk("t5_rst_level", 32'(bus.level), 32'h0);
        chk("t5_rst_state", 32'(bus.state), 32'h0);
        cyc(3);
        chk("t5_rst_hold_level", 32'(bus.level), 32'h0);
        chk("t5_rst_hold_pulse", 32'(bus.press_pulse), 32'h0);
        reset = 1'b0;
        cyc(2);
        chk("t5_no_early_pulse", 32'(bus.press_pulse), 32'h0);
        cyc(1);
        chk("t5_pulse", 32'(bus.press_pulse), 32'h1);
        chk("t5_state", 32'(bus.state), 32'h1);
        chk("t5_pulse_count", 32'(pulse_cnt[0]), 32'd3);
        bus.btn = 4'b0000;
        cyc(30);

        // Long hold then short hold on channel 3
        bus.btn = 4'b1000;
        cyc(40);
        bus.btn = 4'b0000;
        cyc(30);
`ifdef BTN_LONG_PRESS_EN
        chk("t6_long_once", 32'(long_cnt[3]), 32'd1);
`else
        chk("t6_long_tied_low", 32'(long_cnt[0] + long_cnt[1] + long_cnt[2] + long_cnt[3]), 32'd0);
`endif
        bus.btn = 4'b1000;
        cyc(12);
        bus.btn = 4'b0000;
        cyc(30);
`ifdef BTN_LONG_PRESS_EN
        chk("t6_short_no_long", 32'(long_cnt[3]), 32'd1);
`else
        chk("t6_short_tied_low", 32'(long_cnt[3]), 32'd0);
`endif
        chk("t6_pulse_count", 32'(pulse_cnt[3]), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
